// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MiniMips byte bus.
// The CPU pushes bytes into a small TX FIFO, and an FSM shifts each byte out LSB first.
module mmio_uart_tx #(
   parameter logic [7:0]  BASE_ADDR    = 8'hFC,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned DEPTH        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] adr,
   input  logic [7:0] writedata,
   input  logic       memwrite,
   output logic [7:0] rdata,
   output logic       hit_q,
   output logic       tx,
   output logic       irq
);

   localparam int unsigned PW  = $clog2(DEPTH);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned BCW = $clog2(CLKS_PER_BIT);
   localparam logic [BCW-1:0] BIT_LOAD = BCW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state_q, state_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [7:0]     shreg_q, shreg_d;
   logic           tx_d;
   logic           pop;

   logic [7:0]     mem [DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count_q, count_d;
   logic           ovf_q, ovf_d;
   logic [7:0]     last_q;
   logic           push_req, wr_en, ovf_clr;
   logic           irq_d;

   logic [7:0]     off;
   logic           in_win;
   logic [7:0]     rdata_d;
   logic           bit_end;

   assign bit_end  = (bit_cnt_q == '0);
   assign off      = adr - BASE_ADDR;
   assign in_win   = (off[7:2] == 6'd0);
   assign push_req = memwrite && in_win && (off[1:0] == 2'd0);
   assign ovf_clr  = memwrite && in_win && (off[1:0] == 2'd1) && writedata[4];

   // Serialiser next-state: every bit lasts CLKS_PER_BIT edges, and STOP chains straight into the next START.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      idx_d     = idx_q;
      shreg_d   = shreg_q;
      tx_d      = tx;
      pop       = 1'b0;
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (count_q != '0) begin
               pop       = 1'b1;
               shreg_d   = mem[rd_ptr];
               bit_cnt_d = BIT_LOAD;
               state_d   = START;
               tx_d      = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               tx_d      = shreg_q[0];
               shreg_d   = {1'b0, shreg_q[7:1]};
               idx_d     = 3'd0;
               bit_cnt_d = BIT_LOAD;
            end else begin
               bit_cnt_d = bit_cnt_q - BCW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               bit_cnt_d = BIT_LOAD;
               if (idx_q == 3'd7) begin
                  state_d = STOP;
                  tx_d    = 1'b1;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  tx_d    = shreg_q[0];
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end else begin
               bit_cnt_d = bit_cnt_q - BCW'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               if (count_q != '0) begin
                  pop       = 1'b1;
                  shreg_d   = mem[rd_ptr];
                  bit_cnt_d = BIT_LOAD;
                  state_d   = START;
                  tx_d      = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end else begin
               bit_cnt_d = bit_cnt_q - BCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
   always_comb begin
      wr_en   = push_req && ((count_q < CW'(DEPTH)) || pop);
      count_d = count_q;
      if (wr_en && !pop)      count_d = count_q + CW'(1);
      else if (!wr_en && pop) count_d = count_q - CW'(1);
      ovf_d = ovf_q;
      if (push_req && !wr_en) ovf_d = 1'b1;
      else if (ovf_clr)       ovf_d = 1'b0;
      irq_d = (count_d == '0) && (state_d == IDLE);
   end

   always_comb begin
      rdata_d = 8'h00;
      if (in_win) begin
         case (off[1:0])
            2'd0:    rdata_d = last_q;
            2'd1:    rdata_d = {3'b000, ovf_q, (count_q == CW'(DEPTH)),
                                (count_q == '0), (state_q != IDLE), 1'b0};
            2'd2:    rdata_d = 8'(count_q);
            default: rdata_d = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= writedata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         idx_q     <= 3'd0;
         shreg_q   <= 8'h00;
         tx        <= 1'b1;
         irq       <= 1'b1;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         last_q    <= 8'h00;
         rdata     <= 8'h00;
         hit_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         idx_q     <= idx_d;
         shreg_q   <= shreg_d;
         tx        <= tx_d;
         irq       <= irq_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         rdata     <= rdata_d;
         hit_q     <= in_win;
         if (wr_en) begin
            wr_ptr <= wr_ptr + PW'(1);
            last_q <= writedata;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
      end
   end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4.
// Serial bits are sampled in the last cycle of each bit period.
module tb_mmio_uart_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] adr;
   logic [7:0] writedata;
   logic       memwrite;
   logic [7:0] rdata;
   logic       hit_q;
   logic       tx;
   logic       irq;

   int checks = 0;
   int errors = 0;

   mmio_uart_tx #(.BASE_ADDR(8'hFC), .CLKS_PER_BIT(4), .DEPTH(4)) dut (
      .clk(clk), .reset(reset), .adr(adr), .writedata(writedata),
      .memwrite(memwrite), .rdata(rdata), .hit_q(hit_q), .tx(tx), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      adr = a; writedata = d; memwrite = 1'b1;
      tick_n(1);
      memwrite = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp_d, input logic exp_hit);
      adr = a; memwrite = 1'b0;
      tick_n(1);
      chk("rdata", rdata, exp_d);
      chk("hit_q", 8'(hit_q), 8'(exp_hit));
   endtask

   // Called at offset pos (0..3) after the start-bit edge; ends in the last cycle of the stop bit.
   task automatic frame(input logic [7:0] b, input int pos);
      tick_n(3 - pos);
      chk("start_bit", 8'(tx), 8'h00);
      for (int k = 0; k < 8; k++) begin
         tick_n(4);
         chk("data_bit", 8'(tx), 8'(b[k]));
      end
      tick_n(4);
      chk("stop_bit", 8'(tx), 8'h01);
   endtask

   task automatic quiet_line(input int n);
      int lows;
      lows = 0;
      for (int i = 0; i < n; i++) begin
         tick_n(1);
         if (tx !== 1'b1) lows++;
      end
      chk("no_frame", 8'(lows), 8'h00);
   endtask

   initial begin
      reset = 1'b1; adr = 8'h00; writedata = 8'h00; memwrite = 1'b0;
      tick_n(2);
      reset = 1'b0;
      chk("rst_tx", 8'(tx), 8'h01);
      chk("rst_irq", 8'(irq), 8'h01);
      chk("rst_hit", 8'(hit_q), 8'h00);
      chk("rst_rdata", rdata, 8'h00);
      rd(8'hFD, 8'h04, 1'b1);
      rd(8'hFC, 8'h00, 1'b1);

      // Single frame of A5
      wr(8'hFC, 8'hA5);
      chk("lat_tx_hi", 8'(tx), 8'h01);
      chk("irq_pending", 8'(irq), 8'h00);
      tick_n(1);
      chk("lat_tx_lo", 8'(tx), 8'h00);
      frame(8'hA5, 0);
      chk("irq_busy", 8'(irq), 8'h00);
      tick_n(1);
      chk("irq_done", 8'(irq), 8'h01);
      chk("idle_tx", 8'(tx), 8'h01);
      rd(8'hFD, 8'h04, 1'b1);
      rd(8'hFC, 8'hA5, 1'b1);

      // Five back-to-back bytes: first pops immediately, four wait in the FIFO
      for (int i = 0; i < 5; i++) wr(8'hFC, 8'(8'h11 + i));
      frame(8'h11, 3);
      for (int i = 1; i < 5; i++) begin
         tick_n(1);
         chk("no_gap", 8'(tx), 8'h00);
         rd(8'hFE, 8'(4 - i), 1'b1);
         frame(8'(8'h11 + i), 1);
      end
      tick_n(1);
      chk("irq_drained", 8'(irq), 8'h01);
      rd(8'hFD, 8'h04, 1'b1);
      rd(8'hFC, 8'h15, 1'b1);

      // Six bytes in six cycles: the sixth overflows
      for (int i = 0; i < 6; i++) wr(8'hFC, 8'(8'h21 + i));
      rd(8'hFD, 8'h1A, 1'b1);
      wr(8'hFD, 8'h10);
      rd(8'hFD, 8'h0A, 1'b1);
      tick_n(33);
      chk("ovf_next", 8'(tx), 8'h00);
      frame(8'h22, 0);
      for (int i = 3; i < 6; i++) begin
         tick_n(1);
         chk("ovf_gap", 8'(tx), 8'h00);
         frame(8'(8'h20 + i), 0);
      end
      quiet_line(60);
      chk("ovf_irq", 8'(irq), 8'h01);
      rd(8'hFE, 8'h00, 1'b1);

      // Reset in the middle of 3C's data bits with two bytes queued
      wr(8'hFC, 8'h3C);
      wr(8'hFC, 8'h3D);
      wr(8'hFC, 8'h3E);
      tick_n(9);
      reset = 1'b1;
      tick_n(1);
      reset = 1'b0;
      chk("mid_rst_tx", 8'(tx), 8'h01);
      chk("mid_rst_irq", 8'(irq), 8'h01);
      rd(8'hFE, 8'h00, 1'b1);
      rd(8'hFD, 8'h04, 1'b1);
      quiet_line(60);

      // Addresses just outside the window and writes to non-data offsets
      rd(8'h10, 8'h00, 1'b0);
      rd(8'hFB, 8'h00, 1'b0);
      rd(8'hFF, 8'h00, 1'b1);
      wr(8'hFF, 8'h77);
      wr(8'hFB, 8'h55);
      rd(8'hFE, 8'h00, 1'b1);
      rd(8'hFC, 8'h00, 1'b1);
      chk("resv_tx", 8'(tx), 8'h01);
      chk("resv_irq", 8'(irq), 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
